// File: rtl/argmax_sched.sv
// argmax_sched
// ------------
// Time-shares one external argmax unit among NUM_REQ requesters. Only one
// transaction is in flight at a time: a requester's score vector is accepted,
// buffered and launched to the unit. The scheduler then waits for the winning
// index, or gives up after TIMEOUT cycles, and holds the result until the
// consumer accepts it. The next grant goes to the first valid requester after
// the one served last, so requesters are served round-robin.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   req_valid      per-requester offer of a score vector
//   req_ready      per-requester accept (combinational, at most one bit high)
//   req_data       requester i owns slice [i*inData*dataWidth +: inData*dataWidth]
//   mf_in_valid    one-cycle start pulse to the argmax unit
//   mf_in_data     buffered vector presented to the argmax unit
//   mf_out_valid   result pulse from the argmax unit
//   mf_out_data    winning index from the argmax unit
//   rsp_valid      result available (held until rsp_ready)
//   rsp_ready      consumer accept
//   rsp_id         requester that owns the result
//   rsp_class      winning class index (0 on timeout)
//   rsp_err        argmax unit timed out
//   busy           high whenever a transaction is in progress
module argmax_sched #(
    parameter int NUM_REQ   = 2,
    parameter int inData    = 10,
    parameter int dataWidth = 16,
    parameter int outWidth  = $clog2(inData),
    parameter int IDW       = (NUM_REQ > 1 ? $clog2(NUM_REQ) : 1),
    parameter int TIMEOUT   = 63
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*inData*dataWidth-1:0]  req_data,
    output logic                                 mf_in_valid,
    output logic [inData*dataWidth-1:0]          mf_in_data,
    input  logic                                 mf_out_valid,
    input  logic [outWidth-1:0]                  mf_out_data,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [IDW-1:0]                       rsp_id,
    output logic [outWidth-1:0]                  rsp_class,
    output logic                                 rsp_err,
    output logic                                 busy
);

    localparam int VW = inData * dataWidth;
    // Counter must be able to hold TIMEOUT-1, the last WAIT cycle.
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [VW-1:0]       buf_q, buf_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [outWidth-1:0] rsp_class_q, rsp_class_d;
    logic                rsp_err_q, rsp_err_d;

    logic                grant_found;
    logic [IDW-1:0]      grant_idx;
    logic [VW-1:0]       req_vec [NUM_REQ];

    // Split the flat request bus into one vector per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_vec[gi] = req_data[gi*VW +: VW];
        end
    endgenerate

    // Requester index 'off' positions after the one just past last_grant.
    function automatic int wrap_idx(input logic [IDW-1:0] base, input int off);
        int v;
        v = int'(base) + 1 + off;
        if (v >= NUM_REQ) begin
            v = v - NUM_REQ;
        end
        return v;
    endfunction

    // Round-robin search, re-evaluated every cycle so a requester that drops
    // req_valid before being accepted simply loses the grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[wrap_idx(last_grant_q, i)]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(wrap_idx(last_grant_q, i));
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_q == S_IDLE) && grant_found &&
                                   (grant_idx == IDW'(gi));
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        rsp_class_d  = rsp_class_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                // grant_found implies req_valid & req_ready for the winner.
                if (grant_found) begin
                    buf_d   = req_vec[grant_idx];
                    id_d    = grant_idx;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the final WAIT cycle still wins over
                // the timeout.
                if (mf_out_valid) begin
                    rsp_class_d = mf_out_data;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_class_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    last_grant_d = id_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            id_q         <= '0;
            // Pointing at the last requester makes requester 0 win first.
            last_grant_q <= IDW'(NUM_REQ - 1);
            wait_cnt_q   <= '0;
            rsp_class_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            rsp_class_q  <= rsp_class_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign mf_in_valid = (state_q == S_LAUNCH);
    assign mf_in_data  = buf_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = id_q;
    assign rsp_class   = rsp_class_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_argmax_sched.sv
// Testbench for argmax_sched with default parameters. Requester drivers feed
// vectors from per-requester queues, a stub argmax unit answers after a
// programmable delay (0 = never), and a monitor checks every response against
// a queue of hand-computed expectations.
module tb_argmax_sched;

    localparam int NUM_REQ = 2;
    localparam int IND     = 10;
    localparam int DW      = 16;
    localparam int OW      = 4;
    localparam int IDW     = 1;
    localparam int TMO     = 63;
    localparam int VW      = IND * DW;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*VW-1:0]  req_data;
    logic                   mf_in_valid;
    logic [VW-1:0]          mf_in_data;
    logic                   mf_out_valid;
    logic [OW-1:0]          mf_out_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [OW-1:0]          rsp_class;
    logic                   rsp_err;
    logic                   busy;

    argmax_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .mf_in_valid  (mf_in_valid),
        .mf_in_data   (mf_in_data),
        .mf_out_valid (mf_out_valid),
        .mf_out_data  (mf_out_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_class    (rsp_class),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int id;
        int cls;
        int err;
        int lat;   // cycles from mf_in_valid to first rsp_valid
    } exp_t;

    exp_t           exp_q[$];
    logic [VW-1:0]  pend0[$];
    logic [VW-1:0]  pend1[$];
    logic [VW-1:0]  acc_vec;
    int             acc_cyc = 0;
    int             launch_cyc = 0;
    int             stub_delay = 2;
    int             checks = 0;
    int             failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [VW-1:0] vec10(input int s0, s1, s2, s3, s4, s5, s6, s7, s8, s9);
        logic [VW-1:0] v;
        v = '0;
        v[0*DW +: DW] = DW'(s0); v[1*DW +: DW] = DW'(s1);
        v[2*DW +: DW] = DW'(s2); v[3*DW +: DW] = DW'(s3);
        v[4*DW +: DW] = DW'(s4); v[5*DW +: DW] = DW'(s5);
        v[6*DW +: DW] = DW'(s6); v[7*DW +: DW] = DW'(s7);
        v[8*DW +: DW] = DW'(s8); v[9*DW +: DW] = DW'(s9);
        return v;
    endfunction

    // Behaviour of the shared argmax unit: first maximum wins.
    function automatic logic [OW-1:0] argmax_f(input logic [VW-1:0] v);
        int best;
        best = 0;
        for (int k = 1; k < IND; k++) begin
            if (v[k*DW +: DW] > v[best*DW +: DW]) best = k;
        end
        return OW'(best);
    endfunction

    task automatic push_exp(input int id, input int cls, input int err, input int lat);
        exp_t e;
        e.id = id; e.cls = cls; e.err = err; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || pend0.size() != 0 || pend1.size() != 0) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Requester drivers: offer the head of each queue, pop it once accepted.
    initial begin
        logic [NUM_REQ-1:0] acc;
        forever begin
            @(negedge clk);
            acc = rst_n ? (req_valid & req_ready) : '0;
            if (acc != '0) acc_cyc = cyc;
            @(posedge clk); #1;
            if (acc[0]) begin acc_vec = pend0[0]; void'(pend0.pop_front()); end
            if (acc[1]) begin acc_vec = pend1[0]; void'(pend1.pop_front()); end
            req_valid[0]       = (pend0.size() != 0);
            req_data[0 +: VW]  = (pend0.size() != 0) ? pend0[0] : '0;
            req_valid[1]       = (pend1.size() != 0);
            req_data[VW +: VW] = (pend1.size() != 0) ? pend1[0] : '0;
        end
    end

    // Stub argmax unit.
    initial begin
        logic [OW-1:0] cls;
        forever begin
            @(negedge clk);
            if (rst_n && mf_in_valid && stub_delay > 0) begin
                cls = argmax_f(mf_in_data);
                repeat (stub_delay) @(posedge clk);
                #1;
                mf_out_valid = 1'b1;
                mf_out_data  = cls;
                @(posedge clk); #1;
                mf_out_valid = 1'b0;
                mf_out_data  = '0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic           in_resp;
        logic           prev_mfv;
        logic [IDW-1:0] h_id;
        logic [OW-1:0]  h_cls;
        logic           h_err;
        exp_t           e;
        in_resp  = 1'b0;
        prev_mfv = 1'b0;
        h_id = '0; h_cls = '0; h_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_resp  = 1'b0;
                prev_mfv = 1'b0;
            end else begin
                chk("ready_onehot", 64'($countones(req_ready) <= 1), 1);
                if (busy) chk("ready_when_busy", 64'(req_ready), 0);
                chkv("buffer_hold", mf_in_data, acc_vec);
                if (mf_in_valid) begin
                    chk("launch_single_cycle", 64'(prev_mfv), 0);
                    chk("accept_to_launch", 64'(cyc - acc_cyc), 1);
                    launch_cyc = cyc;
                end
                prev_mfv = mf_in_valid;
                if (rsp_valid) begin
                    if (!in_resp) begin
                        in_resp = 1'b1;
                        h_id = rsp_id; h_cls = rsp_class; h_err = rsp_err;
                        chk("rsp_expected", 64'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0)
                            chk("rsp_latency", 64'(cyc - launch_cyc), 64'(exp_q[0].lat));
                    end else begin
                        chk("rsp_stable", 64'({rsp_id, rsp_class, rsp_err}), 64'({h_id, h_cls, h_err}));
                    end
                    if (rsp_ready) begin
                        in_resp = 1'b0;
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            $display("rsp id=%0d class=%0d err=%0d (expected id=%0d class=%0d err=%0d) cycle %0d",
                                     rsp_id, rsp_class, rsp_err, e.id, e.cls, e.err, cyc);
                            chk("rsp_id", 64'(rsp_id), 64'(e.id));
                            chk("rsp_class", 64'(rsp_class), 64'(e.cls));
                            chk("rsp_err", 64'(rsp_err), 64'(e.err));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int n;
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        mf_out_valid = 1'b0;
        mf_out_data = '0;
        rsp_ready = 1'b1;
        acc_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 0);
        chk("reset_req_ready", 64'(req_ready), 0);
        chk("reset_mf_in_valid", 64'(mf_in_valid), 0);
        chk("reset_rsp_valid", 64'(rsp_valid), 0);
        chk("reset_rsp_err", 64'(rsp_err), 0);
        chk("reset_rsp_class", 64'(rsp_class), 0);
        chk("reset_rsp_id", 64'(rsp_id), 0);
        chkv("reset_buffer", mf_in_data, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single request from requester 0: scores 5,9,3,... -> class 1.
        stub_delay = 2;
        push_exp(0, 1, 0, 3);
        pend0.push_back(vec10(5, 9, 3, 1, 2, 4, 0, 7, 6, 8));
        drain();

        // Requester 1 alone, minimum latency unit.
        stub_delay = 1;
        push_exp(1, 8, 0, 2);
        pend1.push_back(vec10(10, 20, 30, 40, 50, 60, 70, 80, 90, 5));
        drain();

        // Fairness: both held valid for four transactions -> 0,1,0,1.
        stub_delay = 3;
        push_exp(0, 0, 0, 4);
        push_exp(1, 9, 0, 4);
        push_exp(0, 5, 0, 4);
        push_exp(1, 3, 0, 4);
        pend0.push_back(vec10(100, 2, 3, 4, 5, 6, 7, 8, 9, 10));
        pend0.push_back(vec10(0, 0, 0, 0, 0, 65535, 0, 0, 0, 1));
        pend1.push_back(vec10(1, 2, 3, 4, 5, 6, 7, 8, 9, 500));
        pend1.push_back(vec10(3, 3, 3, 1000, 3, 3, 3, 3, 3, 3));
        drain();

        // Backpressure: hold rsp_ready low for 10 cycles while another
        // requester waits.
        stub_delay = 2;
        rsp_ready = 1'b0;
        push_exp(0, 8, 0, 3);
        pend0.push_back(vec10(7, 1, 1, 1, 1, 1, 1, 1, 40000, 2));
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_rsp_arrives", 64'(rsp_valid), 1);
        push_exp(1, 0, 0, 3);
        pend1.push_back(vec10(9, 8, 7, 6, 5, 4, 3, 2, 1, 0));
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid_held", 64'(rsp_valid), 1);
            chk("bp_req_ready_low", 64'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        drain();

        // Timeout: unit never answers; then a normal transaction follows.
        stub_delay = 0;
        push_exp(0, 0, 1, TMO + 1);
        pend0.push_back(vec10(4, 44, 4, 4, 4, 4, 4, 4, 4, 4));
        drain();
        stub_delay = 3;
        push_exp(1, 2, 0, 4);
        pend1.push_back(vec10(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        drain();

        // Stray result pulse while idle produces nothing.
        @(posedge clk); #1;
        mf_out_valid = 1'b1;
        mf_out_data  = 4'd5;
        @(posedge clk); #1;
        mf_out_valid = 1'b0;
        mf_out_data  = '0;
        chk("stray_busy", 64'(busy), 0);
        chk("stray_rsp_valid", 64'(rsp_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("stray_rsp_valid_later", 64'(rsp_valid), 0);

        // Result arriving on the final WAIT cycle beats the timeout.
        stub_delay = TMO;
        push_exp(0, 7, 0, TMO + 1);
        pend0.push_back(vec10(11, 12, 13, 14, 15, 16, 17, 999, 19, 20));
        drain();

        // Reset while waiting: transaction abandoned, requester 0 wins next.
        stub_delay = 0;
        pend1.push_back(vec10(1, 1, 1, 1, 1, 1, 1, 1, 1, 77));
        n = 0;
        while (!mf_in_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_test_launch", 64'(mf_in_valid), 1);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        acc_vec = '0;
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_mf_in_valid", 64'(mf_in_valid), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_err", 64'(rsp_err), 0);
        chk("rst_rsp_class", 64'(rsp_class), 0);
        chk("rst_rsp_id", 64'(rsp_id), 0);
        chkv("rst_buffer", mf_in_data, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mf_out_valid = 1'b1;
        mf_out_data  = 4'd3;
        @(posedge clk); #1;
        mf_out_valid = 1'b0;
        mf_out_data  = '0;
        chk("late_pulse_busy", 64'(busy), 0);
        chk("late_pulse_rsp_valid", 64'(rsp_valid), 0);
        stub_delay = 2;
        push_exp(0, 9, 0, 3);
        push_exp(1, 0, 0, 3);
        pend0.push_back(vec10(50, 60, 70, 80, 90, 100, 110, 120, 130, 140));
        pend1.push_back(vec10(300, 200, 100, 0, 0, 0, 0, 0, 0, 0));
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
